// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory bus between fetch (I) and data (D) requesters
// D has priority up to a burst limit while I waits; a grant timeout aborts hung transfers.
module mem_port_arbiter #(
  parameter int D_BURST_MAX = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_done,
  output logic        i_stall,
  input  logic        d_req,
  input  logic        d_write,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        d_stall,
  output logic        m_req,
  output logic        m_write,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ready_n,
  input  logic        m_busy,
  output logic        err_timeout
);

  localparam int DW = $clog2(D_BURST_MAX + 1);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, DONE} state_t;

  state_t        state, state_next;
  logic [DW-1:0] dcnt;
  logic [7:0]    tcnt;
  logic          in_grant, xfer_ok, tmo, finish, d_capped;

  assign in_grant = (state == GRANT_I) || (state == GRANT_D);
  assign xfer_ok  = ~m_ready_n & ~m_busy;
  assign tmo      = (tcnt == 8'(TIMEOUT_CYC));
  assign finish   = in_grant & (xfer_ok | tmo);
  assign d_capped = i_req && (dcnt == DW'(D_BURST_MAX));

  assign i_stall = i_req & ~i_done;
  assign d_stall = d_req & ~d_done;

  always_comb begin
    state_next = state;
    m_req      = 1'b0;
    m_write    = 1'b0;
    m_size     = 2'b00;
    m_addr     = 32'b0;
    m_wdata    = 32'b0;
    case (state)
      IDLE: begin
        if (d_req && !d_capped) state_next = GRANT_D;
        else if (i_req)         state_next = GRANT_I;
      end
      GRANT_I: begin
        m_req  = ~m_busy;
        m_size = 2'b10;
        m_addr = i_addr;
        if (finish) state_next = DONE;
      end
      GRANT_D: begin
        m_req   = ~m_busy;
        m_write = d_write;
        m_size  = d_size;
        m_addr  = d_addr;
        m_wdata = d_write ? d_wdata : 32'b0;
        if (finish) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      i_rdata     <= 32'b0;
      d_rdata     <= 32'b0;
      i_done      <= 1'b0;
      d_done      <= 1'b0;
      err_timeout <= 1'b0;
      dcnt        <= '0;
      tcnt        <= 8'b0;
    end else begin
      i_done <= 1'b0;
      d_done <= 1'b0;
      if (state == GRANT_I && finish) begin
        i_done  <= 1'b1;
        i_rdata <= xfer_ok ? m_rdata : 32'b0;
      end
      if (state == GRANT_D && finish) begin
        d_done  <= 1'b1;
        d_rdata <= (xfer_ok && !d_write) ? m_rdata : 32'b0;
      end
      if (in_grant && !xfer_ok && tmo) err_timeout <= 1'b1;

      // Burst count only matters while I is actually waiting.
      if (!i_req || (state == GRANT_I && finish))
        dcnt <= '0;
      else if (state == GRANT_D && finish && dcnt != DW'(D_BURST_MAX))
        dcnt <= dcnt + DW'(1);

      if (in_grant && state_next == state) tcnt <= tcnt + 8'd1;
      else                                 tcnt <= 8'b0;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
// Vector table plus hand sequences; completions are matched against a scoreboard queue.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_write;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [1:0]  d_size;
  logic [31:0] i_rdata, d_rdata;
  logic        i_done, i_stall, d_done, d_stall;
  logic        m_req, m_write;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata;
  logic [31:0] m_rdata;
  logic        m_ready_n;
  logic        m_busy;
  logic        err_timeout;

  bit resp_en;
  int wait_cyc;
  bit mon_en;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        is_d;
    logic        wr;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          busy;
    int          wt;
    logic [31:0] rdata;
  } vec_t;

  typedef struct {
    logic        is_d;
    logic        wr;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } sb_t;

  vec_t vecs[6];
  sb_t  sbq[$];

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done), .i_stall(i_stall),
    .d_req(d_req), .d_write(d_write), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .d_stall(d_stall),
    .m_req(m_req), .m_write(m_write), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready_n(m_ready_n), .m_busy(m_busy), .err_timeout(err_timeout)
  );

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : (a ^ 32'hC0DE_0000);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic push(input logic is_d, input logic wr, input logic [1:0] sz,
                      input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata);
    sb_t e;
    e.is_d = is_d; e.wr = wr; e.sz = sz; e.addr = addr; e.wdata = wdata; e.rdata = rdata;
    sbq.push_back(e);
  endtask

  // Waits for the chosen requester's done pulse; releases m_busy after `busy` grant cycles.
  task automatic wait_done(input logic is_d, input logic other, input int busy,
                           input int budget, output int lat);
    lat = 0;
    forever begin
      @(posedge clk); #1;
      lat++;
      if (lat == busy + 1) m_busy = 1'b0;
      if (is_d ? d_done : i_done) begin
        check("stall_at_done", 32'(is_d ? d_stall : i_stall), 32'd0);
        if (other) check("other_stall", 32'(is_d ? i_stall : d_stall), 32'd1);
        break;
      end
      check("own_stall", 32'(is_d ? d_stall : i_stall), 32'd1);
      if (lat >= budget) begin
        check("done_wait_expired", 32'(lat), 32'(budget + 1));
        break;
      end
    end
  endtask

  // Memory model: answers a visible request after wait_cyc extra cycles.
  initial begin
    int cnt;
    cnt = 0;
    m_ready_n = 1'b1;
    m_rdata   = 32'b0;
    forever begin
      @(posedge clk); #2;
      if (m_req && resp_en) begin
        if (cnt >= wait_cyc) begin
          m_ready_n = 1'b0;
          m_rdata   = mem_data(m_addr);
        end else begin
          m_ready_n = 1'b1;
          cnt++;
        end
      end else begin
        m_ready_n = 1'b1;
        m_rdata   = 32'h5555_5555;
        cnt = 0;
      end
    end
  end

  initial begin
    sb_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (m_busy) check("req_while_busy", 32'(m_req), 32'd0);
        if (m_req && !m_ready_n) begin
          if (sbq.size() == 0) check("unexpected_xfer", 32'(m_req), 32'd0);
          else begin
            check("bus_addr", m_addr, sbq[0].addr);
            check("bus_write", 32'(m_write), 32'(sbq[0].wr));
            check("bus_size", 32'(m_size), 32'(sbq[0].sz));
            check("bus_wdata", m_wdata, sbq[0].wdata);
          end
        end
        if (i_done || d_done) begin
          if (sbq.size() == 0) check("unexpected_done", {30'b0, i_done, d_done}, 32'd0);
          else begin
            e = sbq.pop_front();
            check("done_both", 32'(i_done & d_done), 32'd0);
            check("done_who", 32'(d_done), 32'(e.is_d));
            check("rdata", e.is_d ? d_rdata : i_rdata, e.rdata);
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   lat;
    vecs[0] = '{1'b0, 1'b0, 2'b10, 32'h0000_0100, 32'h0,         0, 0, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 1'b0, 2'b10, 32'h0000_2000, 32'hFFFF_FFFF, 0, 0, 32'hC0DE_2000};
    vecs[2] = '{1'b1, 1'b1, 2'b10, 32'h0000_0040, 32'h1234_5678, 3, 0, 32'h0};
    vecs[3] = '{1'b1, 1'b0, 2'b00, 32'h0000_0044, 32'hFFFF_FFFF, 0, 2, 32'hC0DE_0044};
    vecs[4] = '{1'b0, 1'b0, 2'b10, 32'h0000_0204, 32'h0,         0, 1, 32'hC0DE_0204};
    vecs[5] = '{1'b1, 1'b1, 2'b01, 32'h0000_0080, 32'hCAFE_F00D, 1, 1, 32'h0};

    rst = 1'b0; i_req = 1'b1; d_req = 1'b1; d_write = 1'b0; d_size = 2'b10;
    i_addr = 32'h100; d_addr = 32'h2000; d_wdata = 32'h0;
    m_busy = 1'b0; resp_en = 1'b1; wait_cyc = 0; mon_en = 1'b0;

    repeat (3) begin
      @(negedge clk);
      check("rst_m_req", 32'(m_req), 32'd0);
      check("rst_done", {30'b0, i_done, d_done}, 32'd0);
      check("rst_err", 32'(err_timeout), 32'd0);
      check("rst_rdata", i_rdata | d_rdata, 32'd0);
    end
    @(posedge clk); #1;
    i_req = 1'b0; d_req = 1'b0; rst = 1'b1; mon_en = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 6; k++) begin
      v = vecs[k];
      if (v.is_d) begin
        d_req = 1'b1; d_write = v.wr; d_size = v.sz; d_addr = v.addr; d_wdata = v.wdata;
        push(1'b1, v.wr, v.sz, v.addr, v.wr ? v.wdata : 32'b0, v.rdata);
      end else begin
        i_req = 1'b1; i_addr = v.addr;
        push(1'b0, 1'b0, 2'b10, v.addr, 32'b0, v.rdata);
      end
      wait_cyc = v.wt;
      m_busy = (v.busy > 0);
      wait_done(v.is_d, 1'b0, v.busy, 400, lat);
      check("latency", 32'(lat), 32'(2 + v.busy + v.wt));
      i_req = 1'b0; d_req = 1'b0; m_busy = 1'b0;
      @(posedge clk); #1;
    end

    // Collision: D load first, then the waiting fetch.
    wait_cyc = 0;
    i_req = 1'b1; i_addr = 32'h300;
    d_req = 1'b1; d_write = 1'b0; d_size = 2'b10; d_addr = 32'h2000; d_wdata = 32'h0;
    push(1'b1, 1'b0, 2'b10, 32'h2000, 32'b0, 32'hC0DE_2000);
    push(1'b0, 1'b0, 2'b10, 32'h300,  32'b0, 32'hC0DE_0300);
    wait_done(1'b1, 1'b1, 0, 50, lat);
    d_req = 1'b0;
    wait_done(1'b0, 1'b0, 0, 50, lat);
    i_req = 1'b0;
    @(posedge clk); #1;

    // Fairness: continuous D stream lets I in after exactly four D completions.
    i_req = 1'b1; i_addr = 32'h304;
    d_req = 1'b1; d_addr = 32'h1000;
    for (int j = 0; j < 4; j++)
      push(1'b1, 1'b0, 2'b10, 32'h1000 + 32'(4 * j), 32'b0, 32'hC0DE_1000 + 32'(4 * j));
    push(1'b0, 1'b0, 2'b10, 32'h304, 32'b0, 32'hC0DE_0304);
    push(1'b1, 1'b0, 2'b10, 32'h1010, 32'b0, 32'hC0DE_1010);
    for (int j = 0; j < 4; j++) begin
      wait_done(1'b1, 1'b1, 0, 50, lat);
      d_addr = 32'h1000 + 32'(4 * (j + 1));
    end
    wait_done(1'b0, 1'b1, 0, 50, lat);
    i_req = 1'b0;
    wait_done(1'b1, 1'b0, 0, 50, lat);
    d_req = 1'b0;
    @(posedge clk); #1;

    // Timeout: memory never answers.
    resp_en = 1'b0;
    d_req = 1'b1; d_write = 1'b0; d_size = 2'b10; d_addr = 32'h3000;
    push(1'b1, 1'b0, 2'b10, 32'h3000, 32'b0, 32'h0);
    wait_done(1'b1, 1'b0, 0, 400, lat);
    check("timeout_latency", 32'(lat), 32'd257);
    check("timeout_err", 32'(err_timeout), 32'd1);
    d_req = 1'b0;
    @(posedge clk); #1;
    check("timeout_sticky", 32'(err_timeout), 32'd1);

    // Reset during a grant: bus drops, nothing completes.
    i_req = 1'b1; i_addr = 32'h400;
    repeat (5) @(posedge clk);
    #1;
    check("grant_before_rst", 32'(m_req), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_m_req", 32'(m_req), 32'd0);
    check("rst_mid_err", 32'(err_timeout), 32'd0);
    check("rst_mid_irdata", i_rdata, 32'd0);
    i_req = 1'b0; rst = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      check("rst_mid_no_done", {30'b0, i_done, d_done}, 32'd0);
    end

    check("sb_empty", 32'(sbq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
